// File: rtl/vec_pkg.sv
// Shared constants and types for the custom-0 vector issue unit.
package vec_pkg;

    // Vector register index width (eight architectural registers)
    localparam int VRW = 3;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    localparam logic [1:0] MODE_VV = 2'b00;
    localparam logic [1:0] MODE_VX = 2'b01;
    localparam logic [1:0] MODE_VI = 2'b10;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SUB = 3'b001;
    localparam logic [2:0] F3_MUL = 3'b010;
    localparam logic [2:0] F3_AND = 3'b011;
    localparam logic [2:0] F3_OR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_e;

    // Every reserved field must be zero; the vs2 high bits are only reserved in VV
    // because VI reuses them as the upper immediate bits and VX ignores them.
    function automatic logic instr_is_legal(input logic [31:0] w);
        logic ok;
        ok = (w[6:0] == OPC_CUSTOM0);
        ok = ok && (w[26:25] != 2'b11);
        ok = ok && (w[14:12] <= F3_OR);
        ok = ok && (w[11:10] == 2'b00);
        ok = ok && (w[19:18] == 2'b00);
        ok = ok && (w[31:27] == 5'b00000);
        ok = ok && !((w[26:25] == MODE_VV) && (w[24:23] != 2'b00));
        return ok;
    endfunction

endpackage

// File: rtl/vector_operations.sv
// Per-lane combinational ALU: result lane = a lane op b, where b is either the
// matching lane of vector_b (VV) or the broadcast scalar (VX / VI).
module vector_operations
    import vec_pkg::*;
#(
    parameter int VECTOR_LENGTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_a,
    input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_b,
    input  logic [DATA_WIDTH-1:0]               scalar,
    input  logic [1:0]                          mode,
    input  logic [2:0]                          funct3,
    output logic [VECTOR_LENGTH*DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] lane_a;
    logic [DATA_WIDTH-1:0] lane_b;
    logic [DATA_WIDTH-1:0] lane_r;

    // Evaluate every lane; arithmetic wraps naturally at DATA_WIDTH bits
    always_comb begin
        result = '0;
        lane_a = '0;
        lane_b = '0;
        lane_r = '0;
        for (int i = 0; i < VECTOR_LENGTH; i++) begin
            lane_a = vector_a[i*DATA_WIDTH +: DATA_WIDTH];
            lane_b = (mode == MODE_VV) ? vector_b[i*DATA_WIDTH +: DATA_WIDTH] : scalar;
            case (funct3)
                F3_ADD:  lane_r = lane_a + lane_b;
                F3_SUB:  lane_r = lane_a - lane_b;
                F3_MUL:  lane_r = lane_a * lane_b;
                F3_AND:  lane_r = lane_a & lane_b;
                F3_OR:   lane_r = lane_a | lane_b;
                default: lane_r = '0;
            endcase
            result[i*DATA_WIDTH +: DATA_WIDTH] = lane_r;
        end
    end

endmodule

// File: rtl/vector_issue_unit.sv
// Multi-cycle issue unit for custom-0 vector instructions.
//
// state  | meaning
// IDLE   | ready for an instruction; external preload writes allowed
// DECODE | legality check on latched word, operand fetch from register file
// EXEC   | ALU result captured into result register
// WB     | done asserted, vd written at the closing edge
module vector_issue_unit
    import vec_pkg::*;
#(
    parameter int VECTOR_LENGTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_VREGS     = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                instr_valid,
    input  logic [31:0]                         instr,
    input  logic [DATA_WIDTH-1:0]               rs1_data,
    output logic                                instr_ready,
    output logic                                done,
    output logic                                illegal,
    input  logic                                vreg_wr_en,
    input  logic [VRW-1:0]                      vreg_wr_addr,
    input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vreg_wr_data,
    input  logic [VRW-1:0]                      vreg_rd_addr,
    output logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vreg_rd_data
);

    localparam int VW = VECTOR_LENGTH * DATA_WIDTH;

    state_e                state;
    logic [31:0]           instr_q;
    logic [DATA_WIDTH-1:0] rs1_q;

    logic [VW-1:0]         vregs [NUM_VREGS];

    logic [VW-1:0]         op_a;
    logic [VW-1:0]         op_b;
    logic [DATA_WIDTH-1:0] op_scalar;
    logic [1:0]            op_mode;
    logic [2:0]            op_funct3;
    logic [VW-1:0]         alu_result;
    logic [VW-1:0]         result_q;

    logic [VRW-1:0]        dec_vd;
    logic [VRW-1:0]        dec_vs1;
    logic [VRW-1:0]        dec_vs2;
    logic [1:0]            dec_mode;
    logic [2:0]            dec_funct3;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic                  dec_legal;

    assign dec_vd     = instr_q[9:7];
    assign dec_vs1    = instr_q[17:15];
    assign dec_vs2    = instr_q[22:20];
    assign dec_mode   = instr_q[26:25];
    assign dec_funct3 = instr_q[14:12];
    assign dec_imm    = {{(DATA_WIDTH-5){instr_q[24]}}, instr_q[24:20]};
    assign dec_legal  = instr_is_legal(instr_q);

    assign instr_ready  = (state == IDLE);
    assign vreg_rd_data = vregs[vreg_rd_addr];

    // ALU sees only registered operands so the EXEC path starts from flops
    vector_operations #(
        .VECTOR_LENGTH (VECTOR_LENGTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ops (
        .vector_a (op_a),
        .vector_b (op_b),
        .scalar   (op_scalar),
        .mode     (op_mode),
        .funct3   (op_funct3),
        .result   (alu_result)
    );

    // Issue FSM: latch, decode/fetch, execute, write back; pulses are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            instr_q   <= '0;
            rs1_q     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_scalar <= '0;
            op_mode   <= '0;
            op_funct3 <= '0;
            result_q  <= '0;
            done      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        rs1_q   <= rs1_data;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        op_a      <= vregs[dec_vs1];
                        op_b      <= vregs[dec_vs2];
                        op_scalar <= (dec_mode == MODE_VI) ? dec_imm : rs1_q;
                        op_mode   <= dec_mode;
                        op_funct3 <= dec_funct3;
                        state     <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= IDLE;
                    end
                end
                EXEC: begin
                    result_q <= alu_result;
                    done     <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register file: write-back has the port in WB, preload only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VREGS; i++) begin
                vregs[i] <= '0;
            end
        end else if (state == WB) begin
            vregs[dec_vd] <= result_q;
        end else if ((state == IDLE) && vreg_wr_en) begin
            vregs[vreg_wr_addr] <= vreg_wr_data;
        end
    end

endmodule

// File: tb/tb_vector_issue_unit.sv
// Directed self-checking bench for vector_issue_unit (8 lanes x 32 bits).
module tb_vector_issue_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [31:0]  rs1_data;
    logic         instr_ready;
    logic         done;
    logic         illegal;
    logic         vreg_wr_en;
    logic [2:0]   vreg_wr_addr;
    logic [255:0] vreg_wr_data;
    logic [2:0]   vreg_rd_addr;
    logic [255:0] vreg_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] mdl [8];

    always #5 clk = ~clk;

    vector_issue_unit #(
        .VECTOR_LENGTH (8),
        .DATA_WIDTH    (32),
        .NUM_VREGS     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .rs1_data     (rs1_data),
        .instr_ready  (instr_ready),
        .done         (done),
        .illegal      (illegal),
        .vreg_wr_en   (vreg_wr_en),
        .vreg_wr_addr (vreg_wr_addr),
        .vreg_wr_data (vreg_wr_data),
        .vreg_rd_addr (vreg_rd_addr),
        .vreg_rd_data (vreg_rd_data)
    );

    function automatic logic [31:0] enc(input logic [1:0] mode, input logic [2:0] f3,
                                        input logic [2:0] vd, input logic [2:0] vs1,
                                        input logic [4:0] f5);
        return {5'b00000, mode, f5, 2'b00, vs1, f3, 2'b00, vd, 7'b0001011};
    endfunction

    function automatic logic [255:0] pk(input logic [31:0] l0, l1, l2, l3, l4, l5, l6, l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [255:0] d);
        vreg_rd_addr = a;
        #1;
        d = vreg_rd_data;
    endtask

    task automatic preload(input logic [2:0] a, input logic [255:0] d);
        vreg_wr_en   = 1'b1;
        vreg_wr_addr = a;
        vreg_wr_data = d;
        step();
        vreg_wr_en   = 1'b0;
    endtask

    // Issues one legal instruction and checks the N..N+3 handshake/done timing
    task automatic do_instr(input logic [31:0] ins, input logic [31:0] rs1, input string nm);
        instr_valid = 1'b1;
        instr       = ins;
        rs1_data    = rs1;
        step();
        instr_valid = 1'b0;
        instr       = '0;
        rs1_data    = '0;
        n_checks++;
        if (instr_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s decode: ready=%b done=%b, required ready=0 done=0", nm, instr_ready, done);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL %s exec: done=%b illegal=%b, required 0 0", nm, done, illegal);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wb: done=%b illegal=%b, required 1 0", nm, done, illegal);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s post: done=%b ready=%b, required 0 1", nm, done, instr_ready);
        end
    endtask

    task automatic test_reset();
        logic [255:0] d;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b done=%b illegal=%b, required 1 0 0",
                     instr_ready, done, illegal);
        end
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), d);
            mdl[r] = '0;
            n_checks++;
            if (d !== 256'h0) begin
                n_fail++;
                $display("FAIL reset_v%0d: got %h required 0", r, d);
            end
        end
    endtask

    task automatic test_preload();
        logic [255:0] d;
        mdl[1] = pk(1, 2, 3, 4, 5, 6, 7, 8);
        mdl[2] = pk(10, 11, 12, 13, 14, 15, 16, 17);
        preload(3'd1, mdl[1]);
        preload(3'd2, mdl[2]);
        read_reg(3'd1, d);
        n_checks++;
        if (d !== mdl[1]) begin
            n_fail++;
            $display("FAIL preload_v1: got %h required %h", d, mdl[1]);
        end
        read_reg(3'd2, d);
        n_checks++;
        if (d !== mdl[2]) begin
            n_fail++;
            $display("FAIL preload_v2: got %h required %h", d, mdl[2]);
        end
    endtask

    task automatic test_arith();
        logic [255:0] d;
        logic [255:0] e;
        do_instr(enc(2'b00, 3'b000, 3'd3, 3'd1, 5'd2), 32'h0, "vv_add");
        e = pk(11, 13, 15, 17, 19, 21, 23, 25);
        mdl[3] = e;
        read_reg(3'd3, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL vv_add_v3: got %h required %h", d, e); end

        do_instr(enc(2'b01, 3'b001, 3'd4, 3'd1, 5'd0), 32'd5, "vx_sub");
        e = pk(32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1, 2, 3);
        read_reg(3'd4, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL vx_sub_v4: got %h required %h", d, e); end

        do_instr(enc(2'b10, 3'b011, 3'd5, 3'd2, 5'b01111), 32'h0, "vi_and");
        e = pk(32'h0A, 32'h0B, 32'h0C, 32'h0D, 32'h0E, 32'h0F, 32'h00, 32'h01);
        mdl[5] = e;
        read_reg(3'd5, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL vi_and_v5: got %h required %h", d, e); end

        do_instr(enc(2'b10, 3'b100, 3'd0, 3'd1, 5'b11111), 32'h0, "vi_or");
        e = {256{1'b1}};
        mdl[0] = e;
        read_reg(3'd0, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL vi_or_v0: got %h required %h", d, e); end

        do_instr(enc(2'b00, 3'b010, 3'd7, 3'd1, 5'd2), 32'h0, "vv_mul");
        e = pk(10, 22, 36, 52, 70, 90, 112, 136);
        mdl[7] = e;
        read_reg(3'd7, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL vv_mul_v7: got %h required %h", d, e); end

        // VX ignores the vs2 high bits; multiply wraps at 32 bits
        do_instr(enc(2'b01, 3'b010, 3'd4, 3'd1, 5'b11000), 32'h8000_0000, "vx_mul_wrap");
        e = pk(32'h80000000, 0, 32'h80000000, 0, 32'h80000000, 0, 32'h80000000, 0);
        mdl[4] = e;
        read_reg(3'd4, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL vx_mul_wrap_v4: got %h required %h", d, e); end

        do_instr(enc(2'b10, 3'b000, 3'd6, 3'd2, 5'b10000), 32'h0, "vi_add_neg");
        e = pk(32'hFFFFFFFA, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1);
        mdl[6] = e;
        read_reg(3'd6, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL vi_add_neg_v6: got %h required %h", d, e); end
    endtask

    task automatic test_alias();
        logic [255:0] d;
        logic [255:0] e;
        do_instr(enc(2'b00, 3'b000, 3'd1, 3'd1, 5'd1), 32'h0, "alias_add");
        e = pk(2, 4, 6, 8, 10, 12, 14, 16);
        mdl[1] = e;
        read_reg(3'd1, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL alias_v1: got %h required %h", d, e); end
    endtask

    task automatic test_illegal();
        logic [31:0]  bad [7];
        logic [255:0] d;
        bad[0] = enc(2'b11, 3'b000, 3'd3, 3'd1, 5'd2);
        bad[1] = enc(2'b00, 3'b101, 3'd3, 3'd1, 5'd2);
        bad[2] = enc(2'b00, 3'b000, 3'd3, 3'd1, 5'd2) ^ 32'h0000_0001;
        bad[3] = enc(2'b00, 3'b000, 3'd3, 3'd1, 5'd2) | 32'h8000_0000;
        bad[4] = enc(2'b01, 3'b000, 3'd3, 3'd1, 5'd2) | 32'h0000_0400;
        bad[5] = enc(2'b10, 3'b000, 3'd3, 3'd1, 5'd2) | 32'h0004_0000;
        bad[6] = enc(2'b00, 3'b000, 3'd3, 3'd1, 5'b01010);
        for (int k = 0; k < 7; k++) begin
            instr_valid = 1'b1;
            instr       = bad[k];
            step();
            instr_valid = 1'b0;
            instr       = '0;
            step();
            n_checks++;
            if (illegal !== 1'b1 || instr_ready !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_%0d: illegal=%b ready=%b done=%b, required 1 1 0",
                         k, illegal, instr_ready, done);
            end
            step();
            n_checks++;
            if (illegal !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_%0d_after: illegal=%b done=%b, required 0 0", k, illegal, done);
            end
        end
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), d);
            n_checks++;
            if (d !== mdl[r]) begin
                n_fail++;
                $display("FAIL illegal_regfile_v%0d: got %h required %h", r, d, mdl[r]);
            end
        end
    endtask

    // Preload and a second instruction offered during DECODE/EXEC/WB are dropped
    task automatic test_ignore_busy();
        logic [255:0] d;
        logic [255:0] e;
        instr_valid = 1'b1;
        instr       = enc(2'b00, 3'b000, 3'd3, 3'd1, 5'd2);
        step();
        instr        = enc(2'b00, 3'b000, 3'd2, 3'd0, 5'd0);
        vreg_wr_en   = 1'b1;
        vreg_wr_addr = 3'd5;
        vreg_wr_data = {8{32'hDEADBEEF}};
        step();
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_done: done=%b required 1", done);
        end
        step();
        instr_valid = 1'b0;
        instr       = '0;
        vreg_wr_en  = 1'b0;
        e = pk(12, 15, 18, 21, 24, 27, 30, 33);
        mdl[3] = e;
        read_reg(3'd3, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL busy_v3: got %h required %h", d, e); end
        read_reg(3'd5, d);
        n_checks++;
        if (d !== mdl[5]) begin n_fail++; $display("FAIL busy_preload_v5: got %h required %h", d, mdl[5]); end
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || instr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_no_latch_%0d: done=%b ready=%b, required 0 1", c, done, instr_ready);
            end
        end
        read_reg(3'd2, d);
        n_checks++;
        if (d !== mdl[2]) begin n_fail++; $display("FAIL busy_v2: got %h required %h", d, mdl[2]); end
    endtask

    task automatic test_reset_abort();
        logic [255:0] d;
        instr_valid = 1'b1;
        instr       = enc(2'b00, 3'b000, 3'd6, 3'd1, 5'd2);
        step();
        instr_valid = 1'b0;
        instr       = '0;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (done !== 1'b0 || illegal !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_outputs: done=%b illegal=%b ready=%b, required 0 0 1",
                     done, illegal, instr_ready);
        end
        rst = 1'b0;
        for (int r = 0; r < 8; r++) mdl[r] = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done_%0d: done=%b required 0", c, done);
            end
        end
        read_reg(3'd6, d);
        n_checks++;
        if (d !== 256'h0) begin n_fail++; $display("FAIL abort_v6: got %h required 0", d); end
        read_reg(3'd1, d);
        n_checks++;
        if (d !== 256'h0) begin n_fail++; $display("FAIL abort_v1_cleared: got %h required 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] d;
        logic [255:0] e;
        preload(3'd1, pk(1, 2, 3, 4, 5, 6, 7, 8));
        preload(3'd2, pk(10, 11, 12, 13, 14, 15, 16, 17));
        do_instr(enc(2'b00, 3'b000, 3'd3, 3'd1, 5'd2), 32'h0, "b2b_first");
        do_instr(enc(2'b00, 3'b000, 3'd7, 3'd3, 5'd1), 32'h0, "b2b_second");
        e = pk(12, 15, 18, 21, 24, 27, 30, 33);
        read_reg(3'd7, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL b2b_v7: got %h required %h", d, e); end
        n_checks++;
        if (d[31:0] !== 32'd12) begin n_fail++; $display("FAIL b2b_v7_lane0: got %h required 0000000c", d[31:0]); end
        read_reg(3'd3, d);
        e = pk(11, 13, 15, 17, 19, 21, 23, 25);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL b2b_v3: got %h required %h", d, e); end
    endtask

    initial begin
        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr        = '0;
        rs1_data     = '0;
        vreg_wr_en   = 1'b0;
        vreg_wr_addr = '0;
        vreg_wr_data = '0;
        vreg_rd_addr = '0;

        test_reset();
        test_preload();
        test_arith();
        test_alias();
        test_illegal();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_issue_unit.md
VECTOR_ISSUE_UNIT -- requirements
Module: vector_issue_unit

Interface
REQ-001 SHALL have parameter VECTOR_LENGTH, default 8, number of lanes per vector register.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per lane.
REQ-003 SHALL have parameter NUM_VREGS, default 8, number of vector registers; register index width VRW = 3.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port instr_valid  in  1  instruction offered.
REQ-007 SHALL have port instr  in  32  custom-0 vector instruction word.
REQ-008 SHALL have port rs1_data  in  DATA_WIDTH  scalar operand for VX mode, sampled with instr.
REQ-009 SHALL have port instr_ready  out  1  unit can accept an instruction.
REQ-010 SHALL have port done  out  1  one-cycle pulse when a result is written back.
REQ-011 SHALL have port illegal  out  1  one-cycle pulse when an instruction is rejected.
REQ-012 SHALL have port vreg_wr_en / vreg_wr_addr / vreg_wr_data  in  1 / VRW / VECTOR_LENGTH*DATA_WIDTH  external preload port.
REQ-013 SHALL have port vreg_rd_addr  in  VRW, and vreg_rd_data  out  VECTOR_LENGTH*DATA_WIDTH, an asynchronous read of the register file.

Function
REQ-014 Encoding SHALL be as follows:
- opcode instr[6:0]=0001011
- vd instr[9:7]; vs1 instr[17:15]; vs2 instr[22:20]
- funct3 instr[14:12]; mode instr[26:25] (00 VV, 01 VX, 10 VI)
- lane 0 occupies bits [DATA_WIDTH-1:0].
REQ-015 The instruction SHALL be illegal if any of the following hold:
- opcode mismatch
- mode=11
- funct3>100
- instr[11:10]≠0, instr[19:18]≠0, or instr[31:27]≠0
- in VV mode only, instr[24:23]≠0.
REQ-016 Operand b SHALL be chosen per lane by mode:
- VV: vs2 lane
- VX: latched rs1_data
- VI: instr[24:20] sign-extended to DATA_WIDTH.
REQ-017 funct3 SHALL select the per-lane operation a op b, with wrap-around modulo 2^DATA_WIDTH for arithmetic: 000 add, 001 sub, 010 multiply (low DATA_WIDTH bits), 011 AND, 100 OR.
REQ-018 The FSM SHALL have states IDLE, DECODE, EXEC, WB; instr_ready=1 only in IDLE.
REQ-019 In IDLE, a handshake (instr_valid && instr_ready) at edge N SHALL latch instr and rs1_data and move to DECODE.
REQ-020 In DECODE, if the instruction is legal the unit SHALL register operands (vs1 and vs2 read at this edge) and move to EXEC.
REQ-021 In DECODE, if the instruction is illegal the unit SHALL move to IDLE with illegal=1 in cycle N+2 and perform no register write.
REQ-022 In EXEC, the unit SHALL capture the vector_operations result into a result register and move to WB.
REQ-023 In WB, done SHALL be 1 (cycle N+3), vd SHALL be written at the closing edge, and the FSM SHALL return to IDLE; vd SHALL be visible on vreg_rd_data from cycle N+4.
REQ-024 Throughput SHALL be at most one instruction per 4 cycles; a dependent instruction issued right after WB SHALL read the updated vd.
REQ-025 vreg_wr_en SHALL be honoured only in IDLE and ignored in all other states; preload writes SHALL be visible on the next cycle.
REQ-026 instr_valid outside IDLE SHALL be ignored, with no latch and no side effect.
REQ-027 vd SHALL be allowed to equal vs1 and/or vs2; operands SHALL be the pre-write values.

Reset
REQ-028 With rst=1 at an edge, the unit SHALL clear state to IDLE, all vector registers to 0, and the latched instruction and result registers to 0; done=0, illegal=0.
REQ-029 instr_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 Reset asserted during DECODE, EXEC or WB SHALL abort the instruction: no vd write and no done pulse.

Structure
REQ-031 Package vec_pkg SHALL hold the custom-0 opcode constant, mode encodings (VV/VX/VI), funct3 operation codes and the FSM state encoding.
REQ-032 The unit SHALL instantiate exactly one combinational sub-module, vector_operations (ports vector_a, vector_b, scalar, mode, funct3, result), fed only from registered operands.

Verification
REQ-033 Preload v1 lanes 0..7 = 1..8 and v2 = 10..17; VV add vd=3 accepted at N -> done at N+3; v3 = 11,13,...,25.
REQ-034 VX sub, vd=4, vs1=1, rs1_data=5 -> v4 lane0 = FFFFFFFC, lane7 = 00000003.
REQ-035 VI AND, vd=5, vs1=2, imm=5'b01111 -> v5 = 0A,0B,0C,0D,0E,0F,00,01; VI OR with imm=5'b11111 -> all lanes FFFFFFFF.
REQ-036 mode=11 or funct3=101 -> illegal=1 at N+2, instr_ready=1 at N+2, no done, register file unchanged.
REQ-037 rst asserted in EXEC of a VV add to vd=6 -> v6 stays 0, no done, all outputs at reset values.
REQ-038 Back-to-back: VV add v3=v1+v2, then VV add v7=v3+v1 accepted at the IDLE after WB -> v7 lane0 = 12; preload attempted while busy is ignored.
